aes_subbytes_pipe: RTL and testbench
====================================

Name: aes_subbytes_pipe

Overview:
Parametrised, pipelined AES SubBytes / InvSubBytes engine.
- Applies the FIPS-197 forward S-box, or optionally the inverse S-box, to LANES independent bytes in parallel.
- Uses a valid/ready elastic pipeline and sustains one transfer per cycle under no backpressure.
- Sits between the AES round controller and ShiftRows/MixColumns, and is reused by key expansion with LANES=4.

Parameters:
- LANES, 16, number of byte lanes processed per transfer (1..16).
- PIPE_STAGES, 2, register stages from input to output (1..3); this is the accept-to-out_valid latency.
- INV_EN, 1, 1 = inverse table instantiated and in_inv honoured; 0 = forward only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transfer offered.
- in_ready  output  1  block can accept the offered transfer this cycle.
- in_data  input  8*LANES  lane i = bits [8i+7:8i].
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8*LANES  substituted bytes, same lane mapping as in_data.
- out_inv  output  1  mode of the transfer currently presented on out_data.
- busy  output  1  OR of all stage valid bits.
- xfer_count  output  32  number of completed output handshakes.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid=0, out_data=0, out_inv=0, busy=0, xfer_count=0. in_ready=1 from the first cycle after reset is released.
- Reset mid-operation flushes every in-flight transfer. Nothing partial ever appears on the output.
- Handshakes:
  - A transfer is accepted when in_valid & in_ready.
  - A transfer is delivered when out_valid & out_ready.
- Lookup:
  - Combinational per lane on the accepted in_data, registered into stage 1.
  - Stages 2..PIPE_STAGES delay the data and mode only.
  - in_inv travels with its data through every stage.
- Stage advance rule:
  - ready_k = !valid_k | ready_(k+1), with ready_(PIPE_STAGES+1) = out_ready.
  - in_ready = ready_1, so it is purely combinational on stage state and out_ready.
- Latency and throughput:
  - Latency is exactly PIPE_STAGES cycles from acceptance to out_valid when there is no backpressure.
  - Throughput is one transfer per cycle.
- Backpressure: while out_valid & !out_ready, out_data and out_inv hold stable and out_valid stays high.
  - The pipeline fills behind the stall.
  - in_ready drops only when all stages are valid and out_ready=0.
  - No transfer is dropped or duplicated.
- Simultaneous accept and deliver on a full pipeline proceed in the same cycle with no bubble.
- INV_EN=0: in_inv is ignored and treated as 0, out_inv is tied 0, and no inverse table logic is generated.
- Tables:
  - The forward table is the standard AES S-box (00→63, 01→7C, 53→ED, FF→16).
  - The inverse table is its exact inverse (63→00, ED→53, 16→FF, 00→52).
- xfer_count:
  - Increments by 1 on each output handshake and wraps FFFFFFFF→00000000.
  - Cleared only by rst.
- Output data is undefined-free: out_data shows the last delivered or currently held stage value and is never X after reset.
- Parameter values outside their legal range must fail elaboration.

Test Plan:
1. Forward, defaults, out_ready=1: in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_inv=0 → exactly 2 cycles later out_valid=1, out_data=d42711aee0bf98f1b8b45de51e415230, out_inv=0; xfer_count=1 after the handshake.
2. Inverse round trip: feed the case 1 output with in_inv=1 → 193de3bea0f4e22b9ac68d2ae9f84808. Then sweep all 256 byte values (replicated across lanes) forward followed by inverse → every byte returns unchanged, and spot checks 00→63, 53→ED, FF→16 hold.
3. Backpressure: stream 5 back-to-back transfers with out_ready=0 for 6 cycles → in_ready falls after 2 accepts, out_data stays stable. Release out_ready → all 5 results appear in order, one per cycle, with no loss or duplication; xfer_count=5.
4. Reset mid-stream: with 2 transfers in flight, assert rst for 1 cycle → next cycle out_valid=0, busy=0, xfer_count=0, in_ready=1. A following transfer completes normally with latency 2.
5. Parameter variants:
   - LANES=4, PIPE_STAGES=1, INV_EN=0, in_data=cf4f3c09, in_inv=1 → after 1 cycle out_data=8a84eb01, out_inv=0.
   - PIPE_STAGES=3 → latency 3.
6. Mixed modes back-to-back: in_data=63636363… with in_inv=1, then in_inv=0 on consecutive cycles → 00000000… (out_inv=1) followed by fbfbfbfb… (out_inv=0) on consecutive cycles.

Source files
------------

// File: rtl/aes_subbytes_pipe_if.sv
// Valid/ready bus for the SubBytes engine: upstream offer plus downstream result.
interface aes_subbytes_pipe_if #(
    parameter int unsigned LANES = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic                 in_inv;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic                 out_inv;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_inv
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_inv
    );
endinterface

// File: rtl/aes_subbytes_pipe.sv
// LANES-wide AES SubBytes / InvSubBytes behind an elastic valid/ready pipeline.
// Each lane's S-box is computed arithmetically: GF(2^8) inverse plus the affine map.
module aes_subbytes_pipe #(
    parameter int unsigned LANES       = 16,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned INV_EN      = 1
) (
    input  logic               clk,
    input  logic               rst,
    aes_subbytes_pipe_if.slave bus,
    output logic               busy,
    output logic [31:0]        xfer_count
);
    localparam int unsigned W    = 8 * LANES;
    localparam int unsigned LAST = PIPE_STAGES - 1;

    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("aes_subbytes_pipe: LANES must be 1..16");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
        $error("aes_subbytes_pipe: PIPE_STAGES must be 1..3");
    end
    if (INV_EN > 1) begin : g_bad_inv
        $error("aes_subbytes_pipe: INV_EN must be 0 or 1");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse and conveniently maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    logic                   inv_sel;
    logic [W-1:0]           sub_c;
    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] inv;
    logic [W-1:0]           dat [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] rdy;

    assign inv_sel = bus.in_inv & (INV_EN != 0);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] b;
        assign b = bus.in_data[8*i +: 8];
        if (INV_EN != 0) begin : g_inv
            assign sub_c[8*i +: 8] = inv_sel ? inv_sbox(b) : fwd_sbox(b);
        end else begin : g_fwd
            assign sub_c[8*i +: 8] = fwd_sbox(b);
        end
    end

    // Stage k can take new data unless it and every stage after it are full and stalled
    always_comb begin
        logic full;
        rdy  = '0;
        full = 1'b0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < PIPE_STAGES; j++) full = full & vld[j];
            rdy[k] = ~full | bus.out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld        <= '0;
            inv        <= '0;
            xfer_count <= 32'd0;
            for (int k = 0; k < PIPE_STAGES; k++) dat[k] <= '0;
        end else begin
            if (rdy[0]) begin
                vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    dat[0] <= sub_c;
                    inv[0] <= inv_sel;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        dat[k] <= dat[k-1];
                        inv[k] <= inv[k-1];
                    end
                end
            end
            if (vld[LAST] & bus.out_ready) xfer_count <= xfer_count + 32'd1;
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[LAST];
    assign bus.out_data  = dat[LAST];
    assign bus.out_inv   = (INV_EN != 0) ? inv[LAST] : 1'b0;
    assign busy          = |vld;

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Bench for aes_subbytes_pipe: scoreboard against a table-driven S-box model,
// plus directed checks on a LANES=4/1-stage/forward-only and a 3-stage instance.
module tb_aes_subbytes_pipe;
    typedef struct packed {
        logic [127:0] data;
        logic         inv;
    } item_t;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        busy0, busy1, busy2;
    logic [31:0] xc0, xc1, xc2;

    aes_subbytes_pipe_if #(.LANES(16)) bif0 ();
    aes_subbytes_pipe_if #(.LANES(4))  bif1 ();
    aes_subbytes_pipe_if #(.LANES(16)) bif2 ();

    aes_subbytes_pipe u0 (.clk(clk), .rst(rst), .bus(bif0), .busy(busy0), .xfer_count(xc0));
    aes_subbytes_pipe #(.LANES(4), .PIPE_STAGES(1), .INV_EN(0))
        u1 (.clk(clk), .rst(rst), .bus(bif1), .busy(busy1), .xfer_count(xc1));
    aes_subbytes_pipe #(.PIPE_STAGES(3))
        u2 (.clk(clk), .rst(rst), .bus(bif2), .busy(busy2), .xfer_count(xc2));

    always #5 clk = ~clk;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];
    int    checks = 0;
    int    errors = 0;
    int    n_acc  = 0;
    int    n_del  = 0;
    bit    rand_rdy = 1'b0;
    item_t pend  [$];
    item_t exp_q [$];
    item_t mon_e;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic item_t mk(input logic [127:0] d, input logic inv);
        item_t t;
        t.data = d;
        t.inv  = inv;
        return t;
    endfunction

    function automatic item_t model(input item_t t);
        item_t r;
        r.inv = t.inv;
        for (int i = 0; i < 16; i++)
            r.data[8*i +: 8] = t.inv ? isbox[t.data[8*i +: 8]] : sbox[t.data[8*i +: 8]];
        return r;
    endfunction

    function automatic item_t rnd_item();
        return mk({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    endfunction

    // Monitor: every output handshake on u0 is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && bif0.out_valid && bif0.out_ready) begin
            n_del++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h with empty scoreboard", bif0.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", bif0.out_data, mon_e.data);
                chk("out_inv", 128'(bif0.out_inv), 128'(mon_e.inv));
            end
        end
    end

    // One clock of the u0 driver: offer the head of pend, record it if accepted
    task automatic step();
        logic acc;
        if (rand_rdy) bif0.out_ready = ($urandom_range(0, 3) != 0);
        if (pend.size() > 0) begin
            bif0.in_valid = 1'b1;
            bif0.in_data  = pend[0].data;
            bif0.in_inv   = pend[0].inv;
        end else begin
            bif0.in_valid = 1'b0;
        end
        @(negedge clk);
        acc = bif0.in_valid & bif0.in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q.push_back(model(pend.pop_front()));
            n_acc++;
        end
        if (pend.size() == 0) bif0.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_complete", 128'(exp_q.size() + pend.size()), 128'd0);
    endtask

    task automatic lat_wait(input int which, output int lat);
        logic v;
        lat = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            v = (which == 0) ? bif0.out_valid : (which == 1) ? bif1.out_valid : bif2.out_valid;
        end while (!v && lat < 10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        pend.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat;
        int    base;
        logic  have;
        logic [127:0] held;
        item_t t;

        for (int i = 0; i < 256; i++) begin
            sbox[i] = SBOX_HEX[2047 - 8*i -: 8];
            isbox[sbox[i]] = 8'(i);
        end

        rst = 1'b1;
        bif0.in_valid = 1'b0; bif0.in_data = '0; bif0.in_inv = 1'b0; bif0.out_ready = 1'b1;
        bif1.in_valid = 1'b0; bif1.in_data = '0; bif1.in_inv = 1'b0; bif1.out_ready = 1'b1;
        bif2.in_valid = 1'b0; bif2.in_data = '0; bif2.in_inv = 1'b0; bif2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_out_valid", 128'(bif0.out_valid), 128'd0);
        chk("rst_busy", 128'(busy0), 128'd0);
        chk("rst_xfer_count", 128'(xc0), 128'd0);
        chk("rst_out_data", bif0.out_data, 128'd0);
        chk("rst_out_inv", 128'(bif0.out_inv), 128'd0);
        chk("rst_in_ready", 128'(bif0.in_ready), 128'd1);

        // FIPS-197 round-1 state, forward
        pend.push_back(mk(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0));
        step();
        lat_wait(0, lat);
        chk("t1_latency", 128'(lat), 128'd2);
        chk("t1_out_data", bif0.out_data, 128'hd42711aee0bf98f1b8b45de51e415230);
        @(posedge clk);
        #1;
        chk("t1_xfer_count", 128'(xc0), 128'd1);

        // inverse round trip, then full byte sweep forward/inverse
        pend.push_back(mk(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1));
        drain();
        for (int v = 0; v < 256; v++) begin
            pend.push_back(mk({16{8'(v)}}, 1'b0));
            pend.push_back(mk({16{sbox[v]}}, 1'b1));
        end
        drain();

        // backpressure: stall output for 6 cycles while offering 5 transfers
        do_reset();
        bif0.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) pend.push_back(rnd_item());
        base = n_acc;
        have = 1'b0;
        held = '0;
        repeat (6) begin
            step();
            if (bif0.out_valid) begin
                if (have) chk("t3_hold_data", bif0.out_data, held);
                else begin held = bif0.out_data; have = 1'b1; end
            end else if (have) begin
                chk("t3_valid_held", 128'(bif0.out_valid), 128'd1);
            end
        end
        chk("t3_accepts_before_full", 128'(n_acc - base), 128'd2);
        chk("t3_in_ready_low", 128'(bif0.in_ready), 128'd0);
        chk("t3_out_valid", 128'(bif0.out_valid), 128'd1);
        base = n_del;
        bif0.out_ready = 1'b1;
        drain();
        chk("t3_delivered", 128'(n_del - base), 128'd5);
        chk("t3_xfer_count", 128'(xc0), 128'd5);

        // reset with two transfers in flight
        pend.push_back(rnd_item());
        pend.push_back(rnd_item());
        step();
        step();
        rst = 1'b1;
        bif0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("t4_out_valid", 128'(bif0.out_valid), 128'd0);
        chk("t4_busy", 128'(busy0), 128'd0);
        chk("t4_xfer_count", 128'(xc0), 128'd0);
        chk("t4_in_ready", 128'(bif0.in_ready), 128'd1);
        pend.push_back(rnd_item());
        step();
        lat_wait(0, lat);
        chk("t4_latency", 128'(lat), 128'd2);
        @(posedge clk);
        #1;
        chk("t4_xfer_count_after", 128'(xc0), 128'd1);

        // mixed modes back to back: consecutive results, no bubble
        pend.push_back(mk({16{8'h63}}, 1'b1));
        pend.push_back(mk({16{8'h63}}, 1'b0));
        base = n_del;
        step();
        step();
        @(negedge clk);
        #1;
        chk("t6_first_delivered", 128'(n_del - base), 128'd1);
        @(negedge clk);
        #1;
        chk("t6_second_delivered", 128'(n_del - base), 128'd2);
        @(posedge clk);
        #1;

        // randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) pend.push_back(rnd_item());
        drain();
        rand_rdy = 1'b0;
        bif0.out_ready = 1'b1;

        // forward-only, 4 lanes, one stage: in_inv must be ignored
        bif1.in_data  = 32'hcf4f3c09;
        bif1.in_inv   = 1'b1;
        bif1.in_valid = 1'b1;
        @(negedge clk);
        chk("v1_in_ready", 128'(bif1.in_ready), 128'd1);
        @(posedge clk);
        #1;
        bif1.in_valid = 1'b0;
        lat_wait(1, lat);
        chk("v1_latency", 128'(lat), 128'd1);
        chk("v1_out_data", 128'(bif1.out_data), 128'h8a84eb01);
        chk("v1_out_inv", 128'(bif1.out_inv), 128'd0);
        @(posedge clk);
        #1;
        chk("v1_xfer_count", 128'(xc1), 128'd1);
        chk("v1_busy_idle", 128'(busy1), 128'd0);

        // three-stage instance
        t = mk({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        bif2.in_data  = t.data;
        bif2.in_inv   = t.inv;
        bif2.in_valid = 1'b1;
        @(negedge clk);
        chk("v2_in_ready", 128'(bif2.in_ready), 128'd1);
        @(posedge clk);
        #1;
        bif2.in_valid = 1'b0;
        lat_wait(2, lat);
        chk("v2_latency", 128'(lat), 128'd3);
        t = model(t);
        chk("v2_out_data", bif2.out_data, t.data);
        chk("v2_out_inv", 128'(bif2.out_inv), 128'(t.inv));
        @(posedge clk);
        #1;
        chk("v2_xfer_count", 128'(xc2), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
